secure_xfer_ctrl: RTL
=====================

SECURE_XFER_CTRL -- requirements
Module: secure_xfer_ctrl

Interface
REQ-001 Parameter: KEY_VALUE, default 16'h0032, access key accepted for both requesters.
REQ-002 Parameter: MAX_FAILS, default 3, consecutive bad-key requests that trigger lockout.
REQ-003 Parameter: LOCK_CYCLES, default 16, lockout duration in clock cycles.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req_mem  input  1  memory-side request; data_mem and key_mem SHALL be held stable while asserted.
REQ-007 data_mem  input  32  memory-side operand.
REQ-008 key_mem  input  16  memory-side key.
REQ-009 req_reg, data_reg, key_reg  input  1/32/16  register-side request, operand and key, with the same rules.
REQ-010 gnt_mem, gnt_reg  output  1  one-cycle accept pulse; the request is consumed in that cycle.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_data  output  32  transformed result, or 0 on error.
REQ-014 out_src  output  1  source of the result: 0 = memory side, 1 = register side.
REQ-015 out_err  output  1  key mismatch for this result.
REQ-016 locked  output  1  high throughout lockout.

Function
REQ-017 FSM states: IDLE, CHECK, S1, S2, S3, S4, RESP, LOCK.
REQ-018 IDLE, at least one request and not locked: grant exactly one requester, latch its data, key and source, then go to CHECK.
REQ-019 Arbitration:
- single request: grant it.
- simultaneous requests: grant the side not granted last.
- after reset, memory side has priority.
REQ-020 CHECK with key == KEY_VALUE: go to S1 and clear the fail counter.
REQ-021 CHECK with a key mismatch:
- increment the fail counter;
- go to RESP with out_err=1 and out_data=0.
REQ-022 Memory-side transform A, one operation per stage, all modulo 2^32:
- S1: t = d - 3
- S2: t = t ^ 2
- S3: t = t + 9
- S4: t = t * 3 (low 32 bits kept)
REQ-023 Register-side transform B, one operation per stage:
- S1: t = d / 3 (unsigned, truncating)
- S2: t = t - 9 (wrap)
- S3: t = ~(t ^ 2)
- S4: t = t + 3 (wrap)
REQ-024 Latency, grant in cycle N:
- valid key: out_valid first high in cycle N+6;
- bad key: out_valid first high in cycle N+2.
REQ-025 RESP handshake:
- out_valid, out_data, out_src and out_err SHALL hold stable until out_valid && out_ready;
- out_valid SHALL deassert in the following cycle.
REQ-026 On the handshake:
- if the fail counter == MAX_FAILS, go to LOCK;
- otherwise go to IDLE.
- The earliest next grant is the cycle after the handshake.
REQ-027 LOCK:
- locked=1, and no grants for exactly LOCK_CYCLES cycles;
- then clear the fail counter, set locked=0 and go to IDLE.
REQ-028 Requests arriving outside IDLE or during LOCK SHALL wait and are never dropped.
REQ-029 A valid-key request SHALL reset the fail count even when earlier failures came from the other requester.

Reset
REQ-030 While rst_n=0 at a clock edge, these SHALL reset:
- state to IDLE;
- gnt_mem, gnt_reg, out_valid, out_err, out_src and locked to 0;
- out_data to 0;
- fail counter and lock counter to 0;
- arbitration priority to the memory side.
REQ-031 Reset during any state, including RESP or LOCK, SHALL discard the in-flight result and cancel lockout.

Structure
REQ-032 Shared package secure_pkg SHALL hold:
- KEY_VALUE default;
- transform constants 3, 9, 2;
- the FSM state enum;
- the source encoding.
REQ-033 The two-input round-robin arbiter SHALL be the sub-module secure_rr_arb2.
REQ-034 Transform stages SHALL share one 32-bit working register, with the operation selected by source.

Verification
REQ-035 req_mem=1, data_mem=0x10, key_mem=0x0032 -> gnt_mem at N, out_data=0x48, out_src=0, out_err=0, out_valid at N+6.
REQ-036 req_reg=1, data_reg=0x30, key_reg=0x0032 -> out_data=0xFFFFFFFD, out_src=1, out_valid at N+6.
REQ-037 req_mem with data_mem=0, valid key -> out_data=0x18 (wrap case).
REQ-038 req_mem and req_reg asserted together from reset, out_ready=1 -> grants alternate: mem, reg, mem, ...
REQ-039 Three bad-key requests (key=0x0000), out_ready=1:
- each returns out_err=1 and out_data=0 at N+2;
- then locked=1 for 16 cycles with no grant despite a pending request;
- then the pending request is granted.
REQ-040 rst_n=0 for one cycle while in S3 with out_ready=0 -> no out_valid for that request, all outputs 0, next request served normally.

Source files
------------

// File: rtl/secure_pkg.sv
// Shared definitions for the secure transfer controller: key default, transform
// constants, FSM state encoding, source encoding and the per-stage transform.
package secure_pkg;

   localparam logic [15:0] KEY_VALUE_DEF = 16'h0032;

   localparam logic [31:0] XF_K3 = 32'd3;
   localparam logic [31:0] XF_K9 = 32'd9;
   localparam logic [31:0] XF_K2 = 32'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_S1,
      ST_S2,
      ST_S3,
      ST_S4,
      ST_RESP,
      ST_LOCK
   } state_e;

   typedef enum logic {
      SRC_MEM = 1'b0,
      SRC_REG = 1'b1
   } src_e;

   // One transform step; memory side runs chain A, register side chain B.
   function automatic logic [31:0] xform_stage(input src_e src, input state_e stage,
                                               input logic [31:0] t);
      logic [31:0] r;
      r = t;
      case (stage)
         ST_S1:   r = (src == SRC_MEM) ? t - XF_K3 : t / XF_K3;
         ST_S2:   r = (src == SRC_MEM) ? t ^ XF_K2 : t - XF_K9;
         ST_S3:   r = (src == SRC_MEM) ? t + XF_K9 : ~(t ^ XF_K2);
         ST_S4:   r = (src == SRC_MEM) ? t * XF_K3 : t + XF_K3;
         default: r = t;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/secure_xfer_ctrl_if.sv
// Request, response and status bundle between the two requesters, the result
// consumer and the controller. The controller uses the slave modport.
interface secure_xfer_ctrl_if;

   logic        req_mem;
   logic [31:0] data_mem;
   logic [15:0] key_mem;
   logic        req_reg;
   logic [31:0] data_reg;
   logic [15:0] key_reg;
   logic        gnt_mem;
   logic        gnt_reg;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_src;
   logic        out_err;
   logic        locked;

   // Requests are level-held until a one-cycle gnt; the result transfers when
   // out_valid && out_ready at a rising edge, and out_valid holds its payload until then.
   modport master (
      output req_mem, data_mem, key_mem, req_reg, data_reg, key_reg, out_ready,
      input  gnt_mem, gnt_reg, out_valid, out_data, out_src, out_err, locked
   );

   modport slave (
      input  req_mem, data_mem, key_mem, req_reg, data_reg, key_reg, out_ready,
      output gnt_mem, gnt_reg, out_valid, out_data, out_src, out_err, locked
   );

endinterface

// File: rtl/secure_rr_arb2.sv
// Two-input round-robin arbiter: on a tie the side not granted last wins;
// after reset the memory side wins the first tie.
module secure_rr_arb2
   import secure_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic req_mem_i,
   input  logic req_reg_i,
   input  logic accept_i,
   output logic valid_o,
   output src_e src_o
);

   src_e last_q;

   always_comb begin
      valid_o = req_mem_i | req_reg_i;
      src_o   = SRC_MEM;
      if (req_mem_i && req_reg_i) begin
         src_o = (last_q == SRC_MEM) ? SRC_REG : SRC_MEM;
      end else if (req_reg_i) begin
         src_o = SRC_REG;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         last_q <= SRC_REG;
      end else if (accept_i) begin
         last_q <= src_o;
      end
   end

endmodule

// File: rtl/secure_xfer_ctrl.sv
// Key-checked transfer controller: grants one of two requesters, verifies the
// key, runs a four-stage transform and locks out after repeated bad keys.
module secure_xfer_ctrl
   import secure_pkg::*;
#(
   parameter logic [15:0] KEY_VALUE   = KEY_VALUE_DEF,
   parameter int unsigned MAX_FAILS   = 3,
   parameter int unsigned LOCK_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   secure_xfer_ctrl_if.slave bus,
   output state_e            state_o
);

   localparam int unsigned       FAIL_W    = $clog2(MAX_FAILS + 1);
   localparam int unsigned       LOCK_W    = $clog2(LOCK_CYCLES + 1);
   localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAILS);
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

   state_e            state_q;
   src_e              src_q;
   logic [31:0]       t_q;
   logic [31:0]       t_d;
   logic [15:0]       key_q;
   logic              err_q;
   logic [FAIL_W-1:0] fail_q;
   logic [LOCK_W-1:0] lock_cnt_q;
   logic              gnt_mem_q;
   logic              gnt_reg_q;
   logic              out_valid_q;
   logic              out_err_q;
   src_e              out_src_q;
   logic [31:0]       out_data_q;
   logic              locked_q;

   logic              arb_valid;
   src_e              arb_src;
   logic              arb_accept;

   assign arb_accept = (state_q == ST_IDLE) && arb_valid;

   secure_rr_arb2 u_arb (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .req_mem_i (bus.req_mem),
      .req_reg_i (bus.req_reg),
      .accept_i  (arb_accept),
      .valid_o   (arb_valid),
      .src_o     (arb_src)
   );

   assign t_d = xform_stage(src_q, state_q, t_q);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         src_q       <= SRC_MEM;
         t_q         <= '0;
         key_q       <= '0;
         err_q       <= 1'b0;
         fail_q      <= '0;
         lock_cnt_q  <= '0;
         gnt_mem_q   <= 1'b0;
         gnt_reg_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_err_q   <= 1'b0;
         out_src_q   <= SRC_MEM;
         out_data_q  <= '0;
         locked_q    <= 1'b0;
      end else begin
         gnt_mem_q <= 1'b0;
         gnt_reg_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (arb_valid) begin
                  gnt_mem_q <= (arb_src == SRC_MEM);
                  gnt_reg_q <= (arb_src == SRC_REG);
                  src_q     <= arb_src;
                  t_q       <= (arb_src == SRC_REG) ? bus.data_reg : bus.data_mem;
                  key_q     <= (arb_src == SRC_REG) ? bus.key_reg : bus.key_mem;
                  state_q   <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (key_q == KEY_VALUE) begin
                  err_q   <= 1'b0;
                  fail_q  <= '0;
                  state_q <= ST_S1;
               end else begin
                  err_q   <= 1'b1;
                  fail_q  <= fail_q + 1'b1;
                  state_q <= ST_RESP;
               end
            end
            ST_S1: begin
               t_q     <= t_d;
               state_q <= ST_S2;
            end
            ST_S2: begin
               t_q     <= t_d;
               state_q <= ST_S3;
            end
            ST_S3: begin
               t_q     <= t_d;
               state_q <= ST_S4;
            end
            ST_S4: begin
               t_q     <= t_d;
               state_q <= ST_RESP;
            end
            // First RESP cycle loads the payload; it then holds until accepted.
            ST_RESP: begin
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
                  out_err_q   <= err_q;
                  out_src_q   <= src_q;
                  out_data_q  <= err_q ? 32'd0 : t_q;
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  if (fail_q == FAIL_MAX) begin
                     locked_q   <= 1'b1;
                     lock_cnt_q <= '0;
                     state_q    <= ST_LOCK;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            ST_LOCK: begin
               if (lock_cnt_q == LOCK_LAST) begin
                  locked_q <= 1'b0;
                  fail_q   <= '0;
                  state_q  <= ST_IDLE;
               end else begin
                  lock_cnt_q <= lock_cnt_q + 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.gnt_mem   = gnt_mem_q;
   assign bus.gnt_reg   = gnt_reg_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;
   assign bus.out_err   = out_err_q;
   assign bus.locked    = locked_q;
   assign state_o       = state_q;

endmodule
